jt10_adpcm_cntn: RTL

JT10_ADPCM_CNTN -- requirements
Module: jt10_adpcm_cntn

---
 rtl/jt10_adpcm_cntn.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/jt10_adpcm_cntn.sv
// Time-multiplexed ADPCM address counters: one CH-entry state ring, one slot updated per cen.
// Loop playback is compiled in only when JT10_ADPCM_LOOP_EN is defined.
module jt10_adpcm_cntn #(
  parameter int unsigned CH = 6,
  parameter int unsigned AW = 12,
  parameter int unsigned SW = 9,
  localparam int unsigned SLW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              adv,
  input  logic [AW+3:0]     addr_in,
  input  logic              up_start,
  input  logic              up_end,
  input  logic              aon,
  input  logic              aoff,
  input  logic              loop_in,
  output logic [SLW-1:0]    slot,
  output logic [AW+SW-2:0]  addr_out,
  output logic              sel,
  output logic              roe_n,
  output logic [3:0]        bank,
  output logic [CH-1:0]     flags,
  input  logic [CH-1:0]     clr_flags
);

  localparam int unsigned CW = AW + SW;

  logic [SLW-1:0]         ptr_q, ptr_d;
  logic [CH-1:0]          on_q, done_q;
  logic [CH-1:0][3:0]     bank_q;
  logic [CH-1:0][AW-1:0]  start_q, end_q;
  logic [CH-1:0][CW-1:0]  cnt_q;

  logic          on_d, done_d;
  logic [3:0]    bank_d;
  logic [AW-1:0] start_d, end_d;
  logic [CW-1:0] cnt_cur, cnt_d;
  logic          ev_set;
  logic [CH-1:0] set;

`ifdef JT10_ADPCM_LOOP_EN
  logic [CH-1:0] loop_q;
  logic          loop_d;
`else
  logic unused_loop_in;
  assign unused_loop_in = loop_in;
`endif

  assign ptr_d = (ptr_q == SLW'(CH - 1)) ? '0 : ptr_q + SLW'(1);

  // Next value of the entry addressed by ptr_q.
  always_comb begin
    on_d    = on_q[ptr_q];
    done_d  = done_q[ptr_q];
    bank_d  = bank_q[ptr_q];
    start_d = start_q[ptr_q];
    end_d   = end_q[ptr_q];
    cnt_cur = cnt_q[ptr_q];
    cnt_d   = cnt_cur;
    ev_set  = 1'b0;
`ifdef JT10_ADPCM_LOOP_EN
    loop_d  = loop_q[ptr_q];
`endif
    if (up_start) start_d = addr_in[AW-1:0];
    if (up_end)   end_d   = addr_in[AW-1:0];
    if (up_start || up_end) bank_d = addr_in[AW+3:AW];

    if (aoff) begin
      ev_set = !done_q[ptr_q];
      on_d   = 1'b0;
      done_d = 1'b1;
    end else if (aon) begin
      if (!on_q[ptr_q]) begin
        on_d   = 1'b1;
        done_d = 1'b0;
        cnt_d  = {start_d, {SW{1'b0}}};
`ifdef JT10_ADPCM_LOOP_EN
        loop_d = loop_in;
`endif
      end
    end else if (adv && on_q[ptr_q] && !done_q[ptr_q]) begin
      if ((cnt_cur[CW-1:SW] == end_d) && (&cnt_cur[SW-1:0])) begin
        ev_set = 1'b1;
`ifdef JT10_ADPCM_LOOP_EN
        if (loop_q[ptr_q]) cnt_d = {start_d, {SW{1'b0}}};
        else               done_d = 1'b1;
`else
        done_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_cur + CW'(1);
      end
    end
  end

  always_comb begin
    set = '0;
    if (cen && ev_set) set[ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      on_q     <= '0;
      done_q   <= '1;
      bank_q   <= '0;
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      slot     <= '0;
      addr_out <= '0;
      sel      <= 1'b0;
      bank     <= 4'd0;
      roe_n    <= 1'b1;
    end else if (cen) begin
      ptr_q          <= ptr_d;
      on_q[ptr_q]    <= on_d;
      done_q[ptr_q]  <= done_d;
      bank_q[ptr_q]  <= bank_d;
      start_q[ptr_q] <= start_d;
      end_q[ptr_q]   <= end_d;
      cnt_q[ptr_q]   <= cnt_d;
      slot           <= ptr_q;
      addr_out       <= cnt_d[CW-1:1];
      sel            <= cnt_d[0];
      bank           <= bank_d;
      roe_n          <= !(on_d && !done_d);
    end
  end

`ifdef JT10_ADPCM_LOOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      loop_q        <= '0;
    else if (cen) loop_q[ptr_q] <= loop_d;
  end
`endif

  // Flags run every clock so the host can clear them while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= ~clr_flags & (flags | set);
  end

endmodule
